// File: rtl/legofpga_kvs_pkg.sv
// Purpose: shared opcodes, status codes, header field positions, table entry layout and FSM states for the key-value store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package legofpga_kvs_pkg;

    localparam logic [7:0] OP_GET = 8'h01;
    localparam logic [7:0] OP_SET = 8'h02;
    localparam logic [7:0] OP_DEL = 8'h03;

    localparam logic [7:0] ST_OK        = 8'h00;
    localparam logic [7:0] ST_NOT_FOUND = 8'h01;
    localparam logic [7:0] ST_BAD_REQ   = 8'h02;

    // Header beat layout: opcode | reserved/status | seq | key
    localparam int OP_MSB  = 63;
    localparam int OP_LSB  = 56;
    localparam int SEQ_MSB = 47;
    localparam int SEQ_LSB = 32;
    localparam int KEY_MSB = 31;
    localparam int KEY_LSB = 0;

    // The tag is kept at full key width (upper bits zero), so the layout
    // does not depend on the table depth chosen by the instantiating module.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [63:0] value;
    } kvs_entry_t;

    localparam int KVS_ENTRY_W = $bits(kvs_entry_t);

    typedef enum logic [2:0] {
        S_INIT,
        S_RX_HDR,
        S_RX_VAL,
        S_DRAIN,
        S_LOOKUP,
        S_TX_HDR,
        S_TX_VAL
    } kvs_state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_GET) || (op == OP_SET) || (op == OP_DEL);
    endfunction

endpackage

// File: rtl/legofpga_axis64_kvs_table.sv
// Purpose: on-chip entry RAM; ports: clear (clr_en_i/clr_addr_i), write (wr_*), synchronous read (rd_addr_i -> rd_data_o).
// Latency: read data valid one cycle after the address; clear/write commit at the edge they are presented.
// Backpressure: none; clear takes priority over write (they are never used together).
module kvs_table
    import legofpga_kvs_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                   clk_i,
    input  logic                   clr_en_i,
    input  logic [AW-1:0]          clr_addr_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [KVS_ENTRY_W-1:0] wr_data_i,
    input  logic [AW-1:0]          rd_addr_i,
    output logic [KVS_ENTRY_W-1:0] rd_data_o
);

    logic [KVS_ENTRY_W-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            mem_q[clr_addr_i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/legofpga_axis64_kvs.sv
// Purpose: AXI4-Stream GET/SET/DEL key-value store; ports: clk_150/sys_rst, from_net_* requests, to_net_* responses, mac_ready gate, init_done.
// Latency: response valid two cycles after the last request beat is accepted; table writes commit at that same edge.
// Backpressure: one request in flight; from_net_tready low outside receive states; responses held while to_net_tready or mac_ready is low.
module legofpga_axis64_kvs
    import legofpga_kvs_pkg::*;
#(
    parameter int TABLE_AW = 8
) (
    input  logic        clk_150,
    input  logic        sys_rst,
    input  logic        mac_ready,
    output logic        init_done,
    input  logic [63:0] from_net_tdata,
    input  logic [7:0]  from_net_tkeep,
    input  logic [63:0] from_net_tuser,
    input  logic        from_net_tvalid,
    input  logic        from_net_tlast,
    output logic        from_net_tready,
    output logic [63:0] to_net_tdata,
    output logic [7:0]  to_net_tkeep,
    output logic [63:0] to_net_tuser,
    output logic        to_net_tvalid,
    output logic        to_net_tlast,
    input  logic        to_net_tready
);

    kvs_state_t          state_q, state_d;
    logic [TABLE_AW-1:0] idx_q, idx_d;
    logic                init_done_q, init_done_d;
    logic                lk_q, lk_d;
    logic                bad_q, bad_d;
    logic [7:0]          op_q, op_d;
    logic [15:0]         seq_q, seq_d;
    logic [31:0]         key_q, key_d;
    logic [63:0]         tuser_q, tuser_d;
    logic [63:0]         val_q, val_d;
    logic [7:0]          status_q, status_d;
    logic [63:0]         rval_q, rval_d;

    logic                clr_en, wr_en;
    kvs_entry_t          wr_entry, rd_entry;
    logic [31:0]         key_tag;
    logic                hit, get_ok;
    logic                unused_tkeep;

    assign unused_tkeep = ^from_net_tkeep;

    kvs_table #(.AW(TABLE_AW)) u_table (
        .clk_i      (clk_150),
        .clr_en_i   (clr_en),
        .clr_addr_i (idx_q),
        .wr_en_i    (wr_en),
        .wr_addr_i  (key_q[TABLE_AW-1:0]),
        .wr_data_i  (wr_entry),
        .rd_addr_i  (key_q[TABLE_AW-1:0]),
        .rd_data_o  (rd_entry)
    );

    assign key_tag = key_q >> TABLE_AW;
    assign hit     = rd_entry.valid && (rd_entry.tag == key_tag);
    assign get_ok  = (op_q == OP_GET) && (status_q == ST_OK);

    always_ff @(posedge clk_150) begin
        if (sys_rst) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            lk_q        <= 1'b0;
            bad_q       <= 1'b0;
            op_q        <= '0;
            seq_q       <= '0;
            key_q       <= '0;
            tuser_q     <= '0;
            val_q       <= '0;
            status_q    <= '0;
            rval_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            lk_q        <= lk_d;
            bad_q       <= bad_d;
            op_q        <= op_d;
            seq_q       <= seq_d;
            key_q       <= key_d;
            tuser_q     <= tuser_d;
            val_q       <= val_d;
            status_q    <= status_d;
            rval_q      <= rval_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        init_done_d     = init_done_q;
        lk_d            = 1'b0;
        bad_d           = bad_q;
        op_d            = op_q;
        seq_d           = seq_q;
        key_d           = key_q;
        tuser_d         = tuser_q;
        val_d           = val_q;
        status_d        = status_q;
        rval_d          = rval_q;
        clr_en          = 1'b0;
        wr_en           = 1'b0;
        wr_entry        = '0;
        from_net_tready = 1'b0;
        to_net_tvalid   = 1'b0;
        to_net_tlast    = 1'b0;
        to_net_tdata    = '0;

        case (state_q)
            S_INIT: begin
                clr_en = 1'b1;
                idx_d  = idx_q + TABLE_AW'(1);
                if (idx_q == '1) begin
                    state_d     = S_RX_HDR;
                    init_done_d = 1'b1;
                end
            end
            S_RX_HDR: begin
                from_net_tready = 1'b1;
                if (from_net_tvalid) begin
                    op_d    = from_net_tdata[OP_MSB:OP_LSB];
                    seq_d   = from_net_tdata[SEQ_MSB:SEQ_LSB];
                    key_d   = from_net_tdata[KEY_MSB:KEY_LSB];
                    tuser_d = from_net_tuser;
                    bad_d   = !op_known(op_d);
                    if (from_net_tlast) begin
                        // A SET with no value beat is malformed.
                        if (op_d == OP_SET) bad_d = 1'b1;
                        state_d = S_LOOKUP;
                    end else if (op_d == OP_SET) begin
                        state_d = S_RX_VAL;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_RX_VAL: begin
                from_net_tready = 1'b1;
                if (from_net_tvalid) begin
                    val_d = from_net_tdata;
                    if (from_net_tlast) begin
                        state_d = S_LOOKUP;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                from_net_tready = 1'b1;
                if (from_net_tvalid && from_net_tlast) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                // First cycle: key_q has just settled and the RAM read is
                // in flight. Second cycle: entry is available to evaluate.
                if (!lk_q) begin
                    lk_d = 1'b1;
                end else begin
                    state_d = S_TX_HDR;
                    rval_d  = rd_entry.value;
                    if (bad_q) begin
                        status_d = ST_BAD_REQ;
                    end else if (op_q == OP_SET) begin
                        wr_en    = 1'b1;
                        wr_entry = '{valid: 1'b1, tag: key_tag, value: val_q};
                        status_d = ST_OK;
                    end else if (op_q == OP_DEL && hit) begin
                        wr_en    = 1'b1;
                        wr_entry = '{valid: 1'b0, tag: rd_entry.tag, value: rd_entry.value};
                        status_d = ST_OK;
                    end else if (op_q == OP_GET && hit) begin
                        status_d = ST_OK;
                    end else begin
                        status_d = ST_NOT_FOUND;
                    end
                end
            end
            S_TX_HDR: begin
                to_net_tvalid = mac_ready;
                to_net_tlast  = !get_ok;
                to_net_tdata  = {op_q, status_q, seq_q, key_q};
                if (mac_ready && to_net_tready) state_d = get_ok ? S_TX_VAL : S_RX_HDR;
            end
            S_TX_VAL: begin
                to_net_tvalid = mac_ready;
                to_net_tlast  = 1'b1;
                to_net_tdata  = rval_q;
                if (mac_ready && to_net_tready) state_d = S_RX_HDR;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign init_done    = init_done_q;
    assign to_net_tkeep = 8'hFF;
    assign to_net_tuser = tuser_q;

endmodule

// File: tb/tb_legofpga_axis64_kvs.sv
module tb_legofpga_axis64_kvs;
    import legofpga_kvs_pkg::*;

    logic        clk_150 = 1'b0;
    logic        sys_rst;
    logic        mac_ready;
    logic        init_done;
    logic [63:0] from_net_tdata;
    logic [7:0]  from_net_tkeep;
    logic [63:0] from_net_tuser;
    logic        from_net_tvalid;
    logic        from_net_tlast;
    logic        from_net_tready;
    logic [63:0] to_net_tdata;
    logic [7:0]  to_net_tkeep;
    logic [63:0] to_net_tuser;
    logic        to_net_tvalid;
    logic        to_net_tlast;
    logic        to_net_tready;

    always #5 clk_150 = ~clk_150;

    legofpga_axis64_kvs #(.TABLE_AW(8)) dut (
        .clk_150         (clk_150),
        .sys_rst         (sys_rst),
        .mac_ready       (mac_ready),
        .init_done       (init_done),
        .from_net_tdata  (from_net_tdata),
        .from_net_tkeep  (from_net_tkeep),
        .from_net_tuser  (from_net_tuser),
        .from_net_tvalid (from_net_tvalid),
        .from_net_tlast  (from_net_tlast),
        .from_net_tready (from_net_tready),
        .to_net_tdata    (to_net_tdata),
        .to_net_tkeep    (to_net_tkeep),
        .to_net_tuser    (to_net_tuser),
        .to_net_tvalid   (to_net_tvalid),
        .to_net_tlast    (to_net_tlast),
        .to_net_tready   (to_net_tready)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] key;
        logic [15:0] seq;
        int          nbeats;
        logic [63:0] val;
        logic [7:0]  exp_st;
        logic [63:0] exp_val;
    } vec_t;

    vec_t vecs[17];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] key, input logic [15:0] seq,
                                input int nb, input logic [63:0] val, input logic [7:0] st,
                                input logic [63:0] ev);
        vec_t v;
        v.op = op; v.key = key; v.seq = seq; v.nbeats = nb; v.val = val;
        v.exp_st = st; v.exp_val = ev;
        return v;
    endfunction

    task automatic send_beat(input string nm, input logic [63:0] d, input logic [63:0] u, input logic last);
        int n = 0;
        from_net_tdata  = d;
        from_net_tuser  = u;
        from_net_tlast  = last;
        from_net_tvalid = 1'b1;
        from_net_tkeep  = 8'h0F;
        while (!from_net_tready && n < 50) begin
            @(negedge clk_150);
            n++;
        end
        check({nm, "_rx_ready"}, from_net_tready, 1'b1);
        @(posedge clk_150);
        #1;
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;
    endtask

    task automatic do_req(input string nm, input vec_t v, input logic [63:0] tu);
        logic v1, v2, v3, gok;
        mac_ready     = 1'b1;
        to_net_tready = 1'b1;
        gok = (v.op == OP_GET) && (v.exp_st == ST_OK);
        send_beat(nm, {v.op, 8'h00, v.seq, v.key}, tu, v.nbeats == 1);
        for (int b = 1; b < v.nbeats; b++)
            send_beat(nm, (b == 1) ? v.val : (64'h5555_AAAA_0000_0000 | 64'(b)), tu ^ 64'hFF, b == v.nbeats - 1);
        v1 = to_net_tvalid;
        @(posedge clk_150); #1;
        v2 = to_net_tvalid;
        @(posedge clk_150); #1;
        v3 = to_net_tvalid;
        check({nm, "_latency"}, {v1, v2, v3}, 3'b001);
        check({nm, "_hdr"}, {to_net_tlast, to_net_tdata}, {!gok, v.op, v.exp_st, v.seq, v.key});
        check({nm, "_tuser"}, to_net_tuser, tu);
        check({nm, "_tkeep"}, to_net_tkeep, 8'hFF);
        @(posedge clk_150); #1;
        if (gok) begin
            check({nm, "_val"}, {to_net_tvalid, to_net_tlast, to_net_tdata}, {2'b11, v.exp_val});
            @(posedge clk_150); #1;
        end
        check({nm, "_idle"}, {to_net_tvalid, from_net_tready}, 2'b01);
    endtask

    initial begin
        logic        early;
        int          got, hold_bad, gate_bad, dup;
        logic        pend;
        logic [128:0] prev;
        logic [63:0] bd[2];
        logic [63:0] bu[2];
        logic        bl[2];

        vecs[0]  = mk(OP_SET, 32'h0000_1234, 16'd7,  2, 64'hDEAD_BEEF_CAFE_F00D, ST_OK,        '0);
        vecs[1]  = mk(OP_GET, 32'h0000_1234, 16'd7,  1, '0,                    ST_OK,        64'hDEAD_BEEF_CAFE_F00D);
        vecs[2]  = mk(OP_GET, 32'h0001_1234, 16'd8,  1, '0,                    ST_NOT_FOUND, '0);
        vecs[3]  = mk(OP_DEL, 32'h0000_1234, 16'd9,  1, '0,                    ST_OK,        '0);
        vecs[4]  = mk(OP_GET, 32'h0000_1234, 16'd10, 1, '0,                    ST_NOT_FOUND, '0);
        vecs[5]  = mk(OP_DEL, 32'h0000_1234, 16'd11, 1, '0,                    ST_NOT_FOUND, '0);
        vecs[6]  = mk(OP_SET, 32'h0000_0042, 16'd12, 2, 64'h1122_3344_5566_7788, ST_OK,        '0);
        vecs[7]  = mk(8'h7F,  32'h0000_0042, 16'd13, 1, '0,                    ST_BAD_REQ,   '0);
        vecs[8]  = mk(OP_SET, 32'h0000_0042, 16'd14, 1, '0,                    ST_BAD_REQ,   '0);
        vecs[9]  = mk(OP_GET, 32'h0000_0042, 16'd15, 1, '0,                    ST_OK,        64'h1122_3344_5566_7788);
        vecs[10] = mk(OP_GET, 32'h0000_0042, 16'd16, 2, 64'h0BAD,              ST_BAD_REQ,   '0);
        vecs[11] = mk(OP_DEL, 32'h0000_0042, 16'd17, 2, 64'h0BAD,              ST_BAD_REQ,   '0);
        vecs[12] = mk(OP_SET, 32'h0000_0042, 16'd18, 3, 64'h9999_9999_9999_9999, ST_BAD_REQ,   '0);
        vecs[13] = mk(OP_GET, 32'h0000_0042, 16'd19, 1, '0,                    ST_OK,        64'h1122_3344_5566_7788);
        vecs[14] = mk(OP_SET, 32'hABCD_0042, 16'd20, 2, 64'h0102_0304_0506_0708, ST_OK,        '0);
        vecs[15] = mk(OP_GET, 32'h0000_0042, 16'd21, 1, '0,                    ST_NOT_FOUND, '0);
        vecs[16] = mk(OP_GET, 32'hABCD_0042, 16'd22, 1, '0,                    ST_OK,        64'h0102_0304_0506_0708);

        sys_rst         = 1'b1;
        mac_ready       = 1'b1;
        to_net_tready   = 1'b1;
        from_net_tdata  = '0;
        from_net_tkeep  = '0;
        from_net_tuser  = '0;
        from_net_tvalid = 1'b0;
        from_net_tlast  = 1'b0;

        repeat (3) @(posedge clk_150);
        #1;
        check("reset_outputs", {init_done, from_net_tready, to_net_tvalid, to_net_tlast}, 4'b0000);
        @(negedge clk_150);
        sys_rst = 1'b0;
        early = 1'b0;
        repeat (255) begin
            @(posedge clk_150); #1;
            if (init_done || from_net_tready) early = 1'b1;
        end
        check("init_not_early", early, 1'b0);
        @(posedge clk_150); #1;
        check("init_done_256", {init_done, from_net_tready}, 2'b11);

        for (int i = 0; i < 17; i++)
            do_req($sformatf("vec%0d", i), vecs[i], 64'hA5A5_0000_0000_0000 | 64'(i));

        // Backpressure: tready toggles, mac_ready drops between header and value.
        send_beat("bp", {OP_GET, 8'h00, 16'h0042, 32'hABCD_0042}, 64'hFEED_FACE_0BAD_F00D, 1'b1);
        got = 0; hold_bad = 0; gate_bad = 0; pend = 1'b0; prev = '0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            to_net_tready = (c % 2 == 0);
            mac_ready     = !(c >= 4 && c <= 8);
            @(negedge clk_150);
            if (!mac_ready && to_net_tvalid) gate_bad++;
            if (to_net_tvalid) begin
                if (pend && {to_net_tlast, to_net_tdata, to_net_tuser} !== prev) hold_bad++;
                if (to_net_tready) begin
                    bd[got] = to_net_tdata;
                    bl[got] = to_net_tlast;
                    bu[got] = to_net_tuser;
                    got++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    prev = {to_net_tlast, to_net_tdata, to_net_tuser};
                end
            end
            @(posedge clk_150); #1;
        end
        to_net_tready = 1'b1;
        mac_ready     = 1'b1;
        dup = 0;
        repeat (5) begin
            @(negedge clk_150);
            if (to_net_tvalid) dup++;
        end
        check("bp_beats", got, 2);
        if (got == 2) begin
            check("bp_hdr", {bl[0], bd[0]}, {1'b0, OP_GET, ST_OK, 16'h0042, 32'hABCD_0042});
            check("bp_val", {bl[1], bd[1]}, {1'b1, 64'h0102_0304_0506_0708});
            check("bp_tuser", {bu[0], bu[1]}, {2{64'hFEED_FACE_0BAD_F00D}});
        end
        check("bp_hold", hold_bad, 0);
        check("bp_mac_gate", gate_bad, 0);
        check("bp_no_dup", dup, 0);

        // Reset in the middle of a SET: packet discarded, table cleared again.
        @(posedge clk_150); #1;
        send_beat("mid", {OP_SET, 8'h00, 16'h0077, 32'h0000_0077}, 64'h1, 1'b0);
        sys_rst = 1'b1;
        @(posedge clk_150); #1;
        check("mid_reset", {init_done, from_net_tready, to_net_tvalid}, 3'b000);
        sys_rst = 1'b0;
        for (int i = 0; i < 300 && !init_done; i++) begin
            @(posedge clk_150); #1;
        end
        check("mid_reinit", init_done, 1'b1);
        do_req("post_reset_get", mk(OP_GET, 32'hABCD_0042, 16'd30, 1, '0, ST_NOT_FOUND, '0), 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
